// File: rtl/decoder_scan_param.sv
// rtl/decoder_scan_param.sv - registered N-to-M line decoder with active-low enable and scan sequencer
// Optional range checking (err output) is built when DEC_RANGE_CHK_EN is defined.
module decoder_scan_param #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int DWELL   = 8,
  parameter int ACT_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   cur_idx,
`ifdef DEC_RANGE_CHK_EN
  output logic               err,
`endif
  output logic               wrap
);

  // Dwell counter must hold 0..DWELL-1; sized so DWELL=1 still gets one bit.
  localparam int CNT_W = $clog2(DWELL + 1);

  localparam logic [NUM_OUT-1:0] INACT     = (ACT_LOW != 0) ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};
  localparam logic [SEL_W:0]     NUM_OUT_W = NUM_OUT[SEL_W:0];
  localparam logic [SEL_W-1:0]   LAST_IDX  = SEL_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0]   DWELL_END = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic               sel_ok;
`ifdef DEC_RANGE_CHK_EN
  logic               err_q, err_d;
`endif

  // Builds the output pattern with exactly one active line at position idx, in the configured polarity.
  function automatic logic [NUM_OUT-1:0] line_of(input logic [SEL_W-1:0] idx);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      v[i] = (idx == SEL_W'(i));
    end
    return (ACT_LOW != 0) ? ~v : v;
  endfunction

  assign sel_ok = ({1'b0, sel} < NUM_OUT_W);

  // Next-state and next-output logic; the mode is re-evaluated every clock from en_n/mode.
  always_comb begin
    state_d = S_IDLE;
    y_d     = INACT;
    idx_d   = idx_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;
`ifdef DEC_RANGE_CHK_EN
    err_d   = 1'b0;
`endif
    if (!en_n) begin
      state_d = mode ? S_SCAN : S_DECODE;
    end
    case (state_d)
      S_DECODE: begin
        if (sel_ok) begin
          y_d   = line_of(sel);
          idx_d = sel;
        end else begin
          // Out-of-range select blanks the outputs but keeps the last valid index.
          idx_d = idx_q;
`ifdef DEC_RANGE_CHK_EN
          err_d = 1'b1;
`endif
        end
      end
      S_SCAN: begin
        if (state_q != S_SCAN) begin
          // Any entry into scan restarts from line 0 with a fresh dwell period.
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q == DWELL_END) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          idx_d = idx_q;
        end
        y_d = line_of(idx_d);
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset dominates all inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= INACT;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef DEC_RANGE_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
`ifdef DEC_RANGE_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign y       = y_q;
  assign cur_idx = idx_q;
  assign wrap    = wrap_q;
`ifdef DEC_RANGE_CHK_EN
  assign err     = err_q;
`endif

endmodule
